// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit for the execute stage: 2-cycle multiply, iterative
// radix-2 restoring divide, one-cycle done pulse with a registered result.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [W-1:0]     ZERO_W   = {W{1'b0}};
    localparam logic [W-1:0]     ONES_W   = {W{1'b1}};
    localparam logic [W-1:0]     ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     MIN_INT  = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic [W-1:0] negate(input logic [W-1:0] v);
        return (~v) + ONE_W;
    endfunction

    function automatic logic [W-1:0] abs_val(input logic [W-1:0] v);
        return v[W-1] ? negate(v) : v;
    endfunction

    state_t           state_r;
    logic [2:0]       funct3_r;
    logic [W-1:0]     op_a_r;
    logic [W-1:0]     op_b_r;
    logic [W-1:0]     quot_r;
    logic [W-1:0]     rem_r;
    logic [W-1:0]     divisor_r;
    logic [CNT_W-1:0] count_r;
    logic             sign_q_r;
    logic             sign_rem_r;
    logic             done_r;
    logic [W-1:0]     result_r;

    logic             div_signed_s;
    logic [W-1:0]     mag_a_s;
    logic [W-1:0]     mag_b_s;
    logic             mul_sa_s;
    logic             mul_sb_s;
    logic [2*W-1:0]   mul_a_ext_s;
    logic [2*W-1:0]   mul_b_ext_s;
    logic [2*W-1:0]   product_s;
    logic [W+1:0]     diff_s;
    logic             borrow_s;
    logic             div_unused_s;
    logic [W-1:0]     rem_step_s;
    logic [W-1:0]     quot_step_s;
    logic [W-1:0]     quot_fix_s;
    logic [W-1:0]     rem_fix_s;

    // Operand magnitudes for the divider setup; funct3[0]=0 marks the signed divides.
    assign div_signed_s = ~funct3_i[0];
    assign mag_a_s      = div_signed_s ? abs_val(rs1_data_i) : rs1_data_i;
    assign mag_b_s      = div_signed_s ? abs_val(rs2_data_i) : rs2_data_i;

    // MULH sign-extends both operands, MULHSU only A; MUL/MULHU treat both as unsigned.
    assign mul_sa_s    = ((funct3_r == 3'b001) || (funct3_r == 3'b010)) & op_a_r[W-1];
    assign mul_sb_s    = (funct3_r == 3'b001) & op_b_r[W-1];
    assign mul_a_ext_s = {{W{mul_sa_s}}, op_a_r};
    assign mul_b_ext_s = {{W{mul_sb_s}}, op_b_r};
    assign product_s   = mul_a_ext_s * mul_b_ext_s;

    // One restoring step; the W+2-bit subtract keeps the 2^(W-1) magnitude of MIN_INT exact.
    assign diff_s       = {1'b0, rem_r, quot_r[W-1]} - {2'b00, divisor_r};
    assign borrow_s     = diff_s[W+1];
    assign div_unused_s = diff_s[W];
    assign rem_step_s   = borrow_s ? {rem_r[W-2:0], quot_r[W-1]} : diff_s[W-1:0];
    assign quot_step_s  = {quot_r[W-2:0], ~borrow_s};

    assign quot_fix_s = sign_q_r   ? negate(quot_r) : quot_r;
    assign rem_fix_s  = sign_rem_r ? negate(rem_r)  : rem_r;

    assign busy_o   = (state_r == ST_MUL) || (state_r == ST_DIV) || (state_r == ST_FIX);
    assign stall_o  = busy_o | (start_i & (state_r == ST_IDLE) & ~flush_i);
    assign done_o   = done_r;
    assign result_o = result_r;

    // Control FSM and datapath registers; reset beats flush, flush beats accept and completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            funct3_r   <= 3'b000;
            op_a_r     <= ZERO_W;
            op_b_r     <= ZERO_W;
            quot_r     <= ZERO_W;
            rem_r      <= ZERO_W;
            divisor_r  <= ZERO_W;
            count_r    <= CNT_ZERO;
            sign_q_r   <= 1'b0;
            sign_rem_r <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= ZERO_W;
        end else if (flush_i) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start_i) begin
                        funct3_r <= funct3_i;
                        op_a_r   <= rs1_data_i;
                        op_b_r   <= rs2_data_i;
                        if (!funct3_i[2]) begin
                            state_r <= ST_MUL;
                        end else if (rs2_data_i == ZERO_W) begin
                            result_r <= funct3_i[1] ? rs1_data_i : ONES_W;
                            done_r   <= 1'b1;
                            state_r  <= ST_DONE;
                        end else if (div_signed_s && (rs1_data_i == MIN_INT) &&
                                     (rs2_data_i == ONES_W)) begin
                            result_r <= funct3_i[1] ? ZERO_W : MIN_INT;
                            done_r   <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            quot_r     <= mag_a_s;
                            rem_r      <= ZERO_W;
                            divisor_r  <= mag_b_s;
                            sign_q_r   <= div_signed_s & (rs1_data_i[W-1] ^ rs2_data_i[W-1]);
                            sign_rem_r <= div_signed_s & rs1_data_i[W-1];
                            count_r    <= CNT_INIT;
                            state_r    <= ST_DIV;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    result_r <= (funct3_r == 3'b000) ? product_s[W-1:0] : product_s[2*W-1:W];
                    done_r   <= 1'b1;
                    state_r  <= ST_DONE;
                end
                ST_DIV: begin
                    rem_r  <= rem_step_s;
                    quot_r <= quot_step_s;
                    if (count_r == CNT_ZERO) begin
                        state_r <= ST_FIX;
                    end else begin
                        count_r <= count_r - CNT_ONE;
                    end
                end
                ST_FIX: begin
                    result_r <= funct3_r[1] ? rem_fix_s : quot_fix_s;
                    done_r   <= 1'b1;
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    // start_i here still belongs to the instruction that just completed.
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: table of RV32M vectors with a result scoreboard,
// plus hand-written flush and reset sequences.
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    localparam int LAT_MUL = 2;
    localparam int LAT_SPC = 1;
    localparam int LAT_DIV = W + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [2:0]   funct3_i;
    logic [W-1:0] rs1_data_i;
    logic [W-1:0] rs2_data_i;
    logic         flush_i;
    logic         stall_o;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;

    muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .funct3_i   (funct3_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [2:0]   f3;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t         vecs[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_res;
    int           tests = 0;
    int           fails = 0;

    function automatic vec_t mk(input string name, input logic [2:0] f3, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
        vec_t v;
        v.name = name; v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op at posedge+1, hold start while stalled, compare when done_o appears.
    task automatic run_op(input vec_t v);
        int           k;
        bit           got;
        logic [W-1:0] e;
        funct3_i   = v.f3;
        rs1_data_i = v.a;
        rs2_data_i = v.b;
        start_i    = 1'b1;
        exp_q.push_back(v.exp);
        #1;
        check({v.name, " stall_accept"}, 32'(stall_o), 32'd1);
        k   = 0;
        got = 1'b0;
        while (!got && k < 60) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) begin
                rs1_data_i = $urandom;
                rs2_data_i = $urandom;
                if (v.lat > 1) check({v.name, " stall_busy"}, 32'(stall_o), 32'd1);
            end
            if (done_o === 1'b1) got = 1'b1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: got no done_o, expected done_o after %0d cycles", v.name, v.lat);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            check({v.name, " result"}, result_o, e);
            check({v.name, " latency"}, 32'(k), 32'(v.lat));
            check({v.name, " done_stall"}, {30'd0, stall_o, busy_o}, 32'd0);
            last_res = e;
        end
        @(posedge clk);
        #1;
        check({v.name, " no_dup"}, 32'(done_o), 32'd0);
        start_i = 1'b0;
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done_o === 1'b1) pulses++;
        end
    endtask

    initial begin
        int pulses;
        rst        = 1'b1;
        start_i    = 1'b0;
        flush_i    = 1'b0;
        funct3_i   = 3'b000;
        rs1_data_i = 32'd0;
        rs2_data_i = 32'd0;
        last_res   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", result_o, 32'd0);
        check("reset flags", {29'd0, done_o, busy_o, stall_o}, 32'd0);
        rst = 1'b0;

        vecs.push_back(mk("mul_7x-3",    F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_MUL));
        vecs.push_back(mk("mulh_min",    F_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_MUL));
        vecs.push_back(mk("mulhsu_min",  F_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_MUL));
        vecs.push_back(mk("mulhu_min",   F_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, LAT_MUL));
        vecs.push_back(mk("mulhu_ones",  F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MUL));
        vecs.push_back(mk("mulh_neg",    F_MULH,   32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, LAT_MUL));
        vecs.push_back(mk("mulhsu_neg",  F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MUL));
        vecs.push_back(mk("div_-7/2",    F_DIV,    32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, LAT_DIV));
        vecs.push_back(mk("rem_-7/2",    F_REM,    32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, LAT_DIV));
        vecs.push_back(mk("divu_big",    F_DIVU,   32'hFFFF_FFFF, 32'h10,         32'h0FFF_FFFF, LAT_DIV));
        vecs.push_back(mk("divu_5/0",    F_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF, LAT_SPC));
        vecs.push_back(mk("rem_5/0",     F_REM,    32'd5,          32'd0,          32'd5,         LAT_SPC));
        vecs.push_back(mk("div_ovf",     F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPC));
        vecs.push_back(mk("rem_ovf",     F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SPC));
        vecs.push_back(mk("remu_0/0",    F_REMU,   32'd0,          32'd0,          32'd0,         LAT_SPC));
        vecs.push_back(mk("mul_100x200", F_MUL,    32'd100,        32'd200,        32'h0000_4E20, LAT_MUL));
        vecs.push_back(mk("divu_100/7",  F_DIVU,   32'd100,        32'd7,          32'd14,        LAT_DIV));
        vecs.push_back(mk("remu_100/7",  F_REMU,   32'd100,        32'd7,          32'd2,         LAT_DIV));
        vecs.push_back(mk("div_7/-2",    F_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_DIV));
        vecs.push_back(mk("rem_7/-2",    F_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         LAT_DIV));
        vecs.push_back(mk("div_min/2",   F_DIV,    32'h8000_0000, 32'd2,          32'hC000_0000, LAT_DIV));
        vecs.push_back(mk("div_min/min", F_DIV,    32'h8000_0000, 32'h8000_0000, 32'd1,         LAT_DIV));
        vecs.push_back(mk("divu_min/-1", F_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_DIV));
        vecs.push_back(mk("remu_min/-1", F_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_DIV));

        foreach (vecs[i]) run_op(vecs[i]);

        // Flush a divide in cycle T+10: idle at T+11, no pulse, result untouched.
        funct3_i   = F_DIVU;
        rs1_data_i = 32'd1000;
        rs2_data_i = 32'd3;
        start_i    = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        flush_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush_div idle", {30'd0, busy_o, done_o}, 32'd0);
        check("flush_div result", result_o, last_res);
        count_pulses(40, pulses);
        check("flush_div no_pulse", 32'(pulses), 32'd0);

        // Flush during the MUL cycle suppresses completion.
        funct3_i   = F_MUL;
        rs1_data_i = 32'd3;
        rs2_data_i = 32'd4;
        start_i    = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush_mul idle", {30'd0, busy_o, done_o}, 32'd0);
        count_pulses(5, pulses);
        check("flush_mul no_pulse", 32'(pulses), 32'd0);
        check("flush_mul result", result_o, last_res);

        // Reset mid-divide abandons the op and clears the result.
        funct3_i   = F_DIV;
        rs1_data_i = 32'hFFFF_FFF9;
        rs2_data_i = 32'd2;
        start_i    = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_div result", result_o, 32'd0);
        check("rst_div flags", {30'd0, busy_o, done_o}, 32'd0);
        count_pulses(40, pulses);
        check("rst_div no_pulse", 32'(pulses), 32'd0);

        run_op(mk("mul_recover", F_MUL, 32'd6, 32'd7, 32'd42, LAT_MUL));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle RV32M arithmetic unit inside the execute stage.
- Its result is muxed into the ALU-result field of the EX/MEM pipeline data that the memory stage consumes.
- Multiplies take 2 cycles. Divides use an iterative radix-2 restoring divider of DATA_WIDTH+1 cycles.
- Stalls the front of the pipeline while busy and presents a one-cycle-valid result for the EX/MEM register to capture.

Parameters:
- DATA_WIDTH, 32, operand/result width. Must be even and ≥ 8.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start_i  input  1  decoded M-extension instruction present in EX (opcode OP, funct7=0000001). Held high by upstream while stall_o is high.
- funct3_i  input  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data_i  input  DATA_WIDTH  forwarded operand A.
- rs2_data_i  input  DATA_WIDTH  forwarded operand B.
- flush_i  input  1  kill in-flight op (branch mispredict / trap).
- stall_o  output  1  hold PC, IF/ID and ID/EX; insert bubble into EX/MEM.
- busy_o  output  1  state is not IDLE and not DONE.
- done_o  output  1  result_o valid this cycle; EX/MEM captures at this edge.
- result_o  output  DATA_WIDTH  final result, registered.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; result_o=0; done_o=0; busy_o=0.
  - Internal quotient, remainder, divisor, count and sign flags cleared.
  - stall_o is combinational, so it reads 0 after reset only if start_i=0.
- stall_o = busy_o | (start_i & state==IDLE & ~flush_i). In DONE, stall_o=0.
- FSM states: IDLE, MUL, DIV, FIX, DONE. Operands and funct3 are latched on accept, i.e. start_i=1 in IDLE with flush_i=0.
- Accept from IDLE:
  - funct3[2]=0: go to MUL.
  - Divide with divisor==0: go to DONE with the special result latched.
  - Signed divide with dividend==MIN_INT and divisor==-1: go to DONE with the special result latched.
  - All other divides: go to DIV with count=DATA_WIDTH-1.
- MUL:
  - Compute the 2*DATA_WIDTH product.
  - Operand sign extension by op: MULH signed×signed; MULHSU signed×unsigned; MULHU and MUL unsigned.
  - Register the low half (MUL) or the high half (others) into result_o, then go to DONE.
  - MUL latency: accept cycle T; done_o=1 in cycle T+2.
- DIV:
  - Setup on accept, signed ops only: take the absolute values of both operands; record sign_q = a_sign^b_sign and sign_r = a_sign.
  - Each cycle: shift {rem,quot} left by 1; trial subtract the divisor; if no borrow, keep the difference and set quot[0]=1.
  - The subtract uses DATA_WIDTH+1 bits, so MIN_INT magnitudes are handled.
  - Decrement count. At count==0 go to FIX. This is DATA_WIDTH cycles in DIV.
- FIX:
  - Negate the quotient if sign_q, and the remainder if sign_r (signed ops only).
  - Select quotient (DIV/DIVU) or remainder (REM/REMU) into result_o, then go to DONE.
  - Normal divide latency: accept T; done_o=1 in cycle T+DATA_WIDTH+2 (T+34 for DATA_WIDTH=32).
- Special-case results, done_o in cycle T+1:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow: DIV gives MIN_INT; REM gives 0.
- DONE:
  - done_o=1 for exactly one cycle, then go to IDLE unconditionally.
  - start_i seen in DONE is the same, already-completed instruction and is ignored.
  - A following M instruction is accepted in the next IDLE cycle (no lost cycle beyond that).
- result_o holds its last value after DONE until the next completion.
- flush_i=1 at an edge in any state:
  - Go to IDLE; done_o=0 next cycle; result_o unchanged.
  - Flush has priority over accept and over completion. A flush in the DONE cycle still lets the EX/MEM register see done_o=1 that cycle; the pipeline flush logic kills it.
- rst has priority over flush_i and over everything else; reset mid-divide abandons the op with no output pulse.
- Operands are never re-sampled after accept, so forwarding changes during busy have no effect.

Test Plan:
- MUL 7×(-3) (rs2=0xFFFFFFFD), start at T: stall_o=1 in T and T+1; done_o=1 at T+2 with result_o=0xFFFFFFEB; done_o=0 at T+3.
- MULH/MULHSU/MULHU with rs1=0x80000000, rs2=0xFFFFFFFF: results 0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
- DIV -7/2 and REM -7/2: done_o at T+34 with 0xFFFFFFFD and 0xFFFFFFFF; DIVU 0xFFFFFFFF/0x10 gives 0x0FFFFFFF.
- DIVU 5/0 gives 0xFFFFFFFF and REM 5/0 gives 5; DIV 0x80000000/-1 gives 0x80000000 and REM gives 0; all with done_o at T+1.
- flush_i asserted at T+10 of a divide: state IDLE at T+11, no done_o pulse, result_o unchanged. rst asserted mid-divide: result_o=0, no pulse.
- Back-to-back MUL then DIVU 100/7: second accept in the cycle after the first done_o; results 0x... then 14, with no duplicate done_o for the first.
